// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline stall/flush controller.
//   stall_bus_t  - 6-bit stall vector: bit0 PC, bit1 if_id, bit2 id_ex,
//                  bit3 ex_mem, bit4 mem_wb, bit5 reserved (always 0)
//   inst_addr_t  - 32-bit instruction address
//   STALL_*      - stall encodings, one per requesting stage
//   pipe_state_e - controller FSM states
//   stall_encode - priority merge of per-stage stall requests
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W     = 6;
  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned PERF_W      = 32;

  typedef logic [STALL_W-1:0]     stall_bus_t;
  typedef logic [INST_ADDR_W-1:0] inst_addr_t;

  // A stalled stage freezes itself and every stage upstream of it
  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_IF   = 6'b000011;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;
  localparam stall_bus_t STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MC_BUSY = 2'd1,
    ST_FLUSH   = 2'd2
  } pipe_state_e;

  // The most downstream requesting stage determines the vector
  function automatic stall_bus_t stall_encode(input logic req_mem,
                                              input logic req_ex,
                                              input logic req_id,
                                              input logic req_if);
    stall_bus_t v;
    v = STALL_NONE;
    if (req_mem)     v = STALL_MEM;
    else if (req_ex) v = STALL_EX;
    else if (req_id) v = STALL_ID;
    else if (req_if) v = STALL_IF;
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_mc_timer.sv
// pipe_ctrl_mc_timer: loadable down-counter timing a multi-cycle EX operation.
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   i_load     - load i_load_val into the counter
//   i_load_val - number of cycles the operation occupies
//   i_abort    - synchronous clear; wins over load
//   o_busy     - counter non-zero (operation in progress)
//   o_last     - counter equals one (final cycle of the operation)
module pipe_ctrl_mc_timer #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_last
);

  logic [CNT_W-1:0] r_count;

  // Count down to zero and stop there
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_abort) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_busy = (r_count != '0);
  assign o_last = (r_count == CNT_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush controller for the 5-stage pipeline.
//   clk, rst            - clock (rising edge), synchronous active-high reset
//   stallreq_if/id/ex/mem - per-stage stall requests
//   mc_start, mc_cycles - launch a multi-cycle EX op lasting mc_cycles cycles
//   excp_valid, excp_pc - exception committed in MEM and its handler address
//   stall               - stall vector for PC and inter-stage registers (combinational)
//   flush, new_pc       - registered one-cycle flush and redirect target
//   mc_busy, mc_done    - multi-cycle op in progress / on its final cycle
// Optional: define PIPE_CTRL_PERF_EN to add saturating perf_stall_cyc and
// perf_flush_cnt counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MC_CNT_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallreq_if,
  input  logic                   stallreq_id,
  input  logic                   stallreq_ex,
  input  logic                   stallreq_mem,
  input  logic                   mc_start,
  input  logic [MC_CNT_W-1:0]    mc_cycles,
  input  logic                   excp_valid,
  input  logic [INST_ADDR_W-1:0] excp_pc,
  output logic [STALL_W-1:0]     stall,
  output logic                   flush,
  output logic [INST_ADDR_W-1:0] new_pc,
  output logic                   mc_busy,
  output logic                   mc_done
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]      perf_stall_cyc,
  output logic [PERF_W-1:0]      perf_flush_cnt
`endif
);

  pipe_state_e r_state;
  logic        r_flush;
  inst_addr_t  r_new_pc;

  logic        w_mc_load;
  logic        w_mc_busy;
  logic        w_mc_last;
  logic        w_int_ex_req;
  stall_bus_t  w_stall;

  // A zero-length op is ignored; an exception in the same cycle wins
  assign w_mc_load = (r_state == ST_IDLE) && mc_start && (mc_cycles != '0) && !excp_valid;

  pipe_ctrl_mc_timer #(
    .CNT_W (MC_CNT_W)
  ) u_mc_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_mc_load),
    .i_load_val (mc_cycles),
    .i_abort    (excp_valid),
    .o_busy     (w_mc_busy),
    .o_last     (w_mc_last)
  );

  // EX holds the pipe while the op runs, releasing it on the result cycle
  assign w_int_ex_req = w_mc_busy && !w_mc_last;

  // Flush must never be blocked, so it and a pending exception mask all stalls
  always_comb begin
    w_stall = STALL_NONE;
    if (!excp_valid && (r_state != ST_FLUSH)) begin
      w_stall = stall_encode(stallreq_mem, stallreq_ex | w_int_ex_req,
                             stallreq_id, stallreq_if);
    end
  end

  // Controller FSM with registered flush/redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_flush  <= 1'b0;
      r_new_pc <= '0;
    end else if (excp_valid) begin
      r_state  <= ST_FLUSH;
      r_flush  <= 1'b1;
      r_new_pc <= excp_pc;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_mc_load) r_state <= ST_MC_BUSY;
        end
        ST_MC_BUSY: begin
          if (w_mc_last) r_state <= ST_IDLE;
        end
        ST_FLUSH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall   = w_stall;
  assign flush   = r_flush;
  assign new_pc  = r_new_pc;
  assign mc_busy = w_mc_busy;
  assign mc_done = w_mc_last;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] r_perf_stall_cyc;
  logic [PERF_W-1:0] r_perf_flush_cnt;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall_cyc <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if ((w_stall != STALL_NONE) && (r_perf_stall_cyc != '1)) begin
        r_perf_stall_cyc <= r_perf_stall_cyc + PERF_W'(1);
      end
      if (r_flush && (r_perf_flush_cnt != '1)) begin
        r_perf_flush_cnt <= r_perf_flush_cnt + PERF_W'(1);
      end
    end
  end

  assign perf_stall_cyc = r_perf_stall_cyc;
  assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the stall/flush controller.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        mc_start;
  logic [5:0]  mc_cycles;
  logic        excp_valid;
  logic [31:0] excp_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mc_busy;
  logic        mc_done;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc;
  logic [31:0] perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model: remaining busy cycles, flush this cycle, redirect PC
  int          m_rem;
  bit          m_fl;
  logic [31:0] m_pc;
  int          m_perf_stall;
  int          m_perf_flush;

  pipe_ctrl #(.MC_CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .mc_start     (mc_start),
    .mc_cycles    (mc_cycles),
    .excp_valid   (excp_valid),
    .excp_pc      (excp_pc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .mc_busy      (mc_busy),
    .mc_done      (mc_done)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected stall vector for the current cycle
  function automatic logic [5:0] model_stall();
    if (excp_valid || m_fl) return 6'b000000;
    if (stallreq_mem)                 return 6'b011111;
    if (stallreq_ex || (m_rem > 1))   return 6'b001111;
    if (stallreq_id)                  return 6'b000111;
    if (stallreq_if)                  return 6'b000011;
    return 6'b000000;
  endfunction

  task automatic clear_inputs();
    stallreq_if  = 1'b0;
    stallreq_id  = 1'b0;
    stallreq_ex  = 1'b0;
    stallreq_mem = 1'b0;
    mc_start     = 1'b0;
    mc_cycles    = 6'd0;
    excp_valid   = 1'b0;
    excp_pc      = 32'h0;
  endtask

  // Advance one clock: the model consumes this cycle's inputs at the edge
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_rem = 0; m_fl = 1'b0; m_pc = 32'h0;
      m_perf_stall = 0; m_perf_flush = 0;
    end else begin
      if (model_stall() != 6'b0) m_perf_stall++;
      if (m_fl) m_perf_flush++;
      if (excp_valid) begin
        m_rem = 0; m_fl = 1'b1; m_pc = excp_pc;
      end else begin
        if (m_rem > 0) m_rem--;
        else if (mc_start && (mc_cycles != 6'd0) && !m_fl) m_rem = int'(mc_cycles);
        m_fl = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (stall !== 6'b0)    begin errors++; $display("FAIL reset_stall got %b exp 000000", stall); end
    checks++; if (flush !== 1'b0)    begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
    checks++; if (new_pc !== 32'h0)  begin errors++; $display("FAIL reset_new_pc got %h exp 0", new_pc); end
    checks++; if (mc_busy !== 1'b0)  begin errors++; $display("FAIL reset_mc_busy got %b exp 0", mc_busy); end
    checks++; if (mc_done !== 1'b0)  begin errors++; $display("FAIL reset_mc_done got %b exp 0", mc_done); end
    tick();
  endtask

  task automatic test_stall_priority();
    clear_inputs();
    stallreq_id = 1'b1; stallreq_mem = 1'b1; #1;
    checks++; if (stall !== 6'b011111) begin errors++; $display("FAIL prio_id_mem got %b exp 011111", stall); end
    tick();
    stallreq_mem = 1'b0; #1;
    checks++; if (stall !== 6'b000111) begin errors++; $display("FAIL prio_id got %b exp 000111", stall); end
    tick();
    stallreq_id = 1'b0; stallreq_if = 1'b1; stallreq_ex = 1'b1; #1;
    checks++; if (stall !== 6'b001111) begin errors++; $display("FAIL prio_ex_if got %b exp 001111", stall); end
    tick();
    stallreq_ex = 1'b0; #1;
    checks++; if (stall !== 6'b000011) begin errors++; $display("FAIL prio_if got %b exp 000011", stall); end
    tick();
    stallreq_mem = 1'b1; excp_valid = 1'b1; excp_pc = 32'h40; #1;
    checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL prio_excp_mask got %b exp 000000", stall); end
    tick();
    clear_inputs(); #1;
    checks++; if (flush !== 1'b1 || new_pc !== 32'h40) begin errors++; $display("FAIL prio_flush got %b/%h exp 1/00000040", flush, new_pc); end
    tick();
  endtask

  task automatic test_mc_op();
    clear_inputs();
    mc_start = 1'b1; mc_cycles = 6'd4;
    tick();
    clear_inputs();
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++; if (mc_busy !== 1'b1) begin errors++; $display("FAIL mc4_busy cyc %0d got %b exp 1", i, mc_busy); end
      checks++; if (stall !== ((i < 4) ? 6'b001111 : 6'b000000)) begin errors++; $display("FAIL mc4_stall cyc %0d got %b", i, stall); end
      checks++; if (mc_done !== (i == 4)) begin errors++; $display("FAIL mc4_done cyc %0d got %b exp %b", i, mc_done, (i == 4)); end
      tick();
    end
    #1;
    checks++; if (mc_busy !== 1'b0 || mc_done !== 1'b0) begin errors++; $display("FAIL mc4_end got %b/%b exp 0/0", mc_busy, mc_done); end
  endtask

  task automatic test_mc_edge();
    clear_inputs();
    mc_start = 1'b1; mc_cycles = 6'd1; #1;
    checks++; if (stall !== 6'b0) begin errors++; $display("FAIL mc1_launch_stall got %b exp 000000", stall); end
    tick();
    clear_inputs(); #1;
    checks++; if (mc_busy !== 1'b1 || mc_done !== 1'b1 || stall !== 6'b0) begin errors++; $display("FAIL mc1 got busy %b done %b stall %b exp 1 1 000000", mc_busy, mc_done, stall); end
    tick(); #1;
    checks++; if (mc_busy !== 1'b0) begin errors++; $display("FAIL mc1_end got %b exp 0", mc_busy); end
    mc_start = 1'b1; mc_cycles = 6'd0;
    tick();
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (mc_busy !== 1'b0 || stall !== 6'b0) begin errors++; $display("FAIL mc0 got busy %b stall %b exp 0 000000", mc_busy, stall); end
      tick();
    end
  endtask

  task automatic test_exception_abort();
    bit done_seen;
    done_seen = 1'b0;
    clear_inputs();
    mc_start = 1'b1; mc_cycles = 6'd10;
    tick();
    clear_inputs();
    tick();
    excp_valid = 1'b1; excp_pc = 32'h0000_0380; #1;
    checks++; if (stall !== 6'b0) begin errors++; $display("FAIL abort_excp_stall got %b exp 000000", stall); end
    if (mc_done === 1'b1) done_seen = 1'b1;
    tick();
    clear_inputs(); #1;
    checks++; if (flush !== 1'b1)          begin errors++; $display("FAIL abort_flush got %b exp 1", flush); end
    checks++; if (new_pc !== 32'h380)      begin errors++; $display("FAIL abort_new_pc got %h exp 00000380", new_pc); end
    checks++; if (stall !== 6'b0)          begin errors++; $display("FAIL abort_stall got %b exp 000000", stall); end
    checks++; if (mc_busy !== 1'b0)        begin errors++; $display("FAIL abort_busy got %b exp 0", mc_busy); end
    tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      if (mc_done === 1'b1) done_seen = 1'b1;
      if (i == 0) begin
        checks++; if (flush !== 1'b0 || new_pc !== 32'h380) begin errors++; $display("FAIL abort_idle got flush %b pc %h exp 0 00000380", flush, new_pc); end
      end
      tick();
    end
    checks++; if (done_seen) begin errors++; $display("FAIL abort_no_done got 1 exp 0"); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    excp_valid = 1'b1; excp_pc = 32'h100;
    tick();
    excp_pc = 32'h200; #1;
    checks++; if (flush !== 1'b1 || new_pc !== 32'h100) begin errors++; $display("FAIL b2b_first got %b/%h exp 1/00000100", flush, new_pc); end
    tick();
    clear_inputs(); #1;
    checks++; if (flush !== 1'b1 || new_pc !== 32'h200) begin errors++; $display("FAIL b2b_second got %b/%h exp 1/00000200", flush, new_pc); end
    tick(); #1;
    checks++; if (flush !== 1'b0 || new_pc !== 32'h200) begin errors++; $display("FAIL b2b_after got %b/%h exp 0/00000200", flush, new_pc); end
`ifdef PIPE_CTRL_PERF_EN
    checks++; if (perf_flush_cnt !== 32'd2) begin errors++; $display("FAIL b2b_perf_flush got %0d exp 2", perf_flush_cnt); end
`endif
    tick();
  endtask

  task automatic test_reset_mid_op();
    clear_inputs();
    mc_start = 1'b1; mc_cycles = 6'd8;
    tick();
    clear_inputs();
    tick();
    rst = 1'b1; excp_valid = 1'b1; excp_pc = 32'hDEAD_0000;
    tick();
    rst = 1'b0; clear_inputs(); #1;
    checks++; if (flush !== 1'b0 || new_pc !== 32'h0 || mc_busy !== 1'b0 || stall !== 6'b0) begin
      errors++; $display("FAIL rst_mid got flush %b pc %h busy %b stall %b exp 0 0 0 000000", flush, new_pc, mc_busy, stall);
    end
    tick();
  endtask

  task automatic test_random();
    logic [5:0] exp_stall;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      stallreq_if  = ($urandom_range(0, 3) == 0);
      stallreq_id  = ($urandom_range(0, 4) == 0);
      stallreq_ex  = ($urandom_range(0, 6) == 0);
      stallreq_mem = ($urandom_range(0, 8) == 0);
      mc_start     = ($urandom_range(0, 3) == 0);
      mc_cycles    = 6'($urandom_range(0, 12));
      excp_valid   = ($urandom_range(0, 14) == 0);
      excp_pc      = $urandom;
      #1;
      exp_stall = model_stall();
      checks++; if (stall !== exp_stall) begin errors++; $display("FAIL rnd_stall cyc %0d got %b exp %b", c, stall, exp_stall); end
      checks++; if (flush !== m_fl) begin errors++; $display("FAIL rnd_flush cyc %0d got %b exp %b", c, flush, m_fl); end
      checks++; if (new_pc !== m_pc) begin errors++; $display("FAIL rnd_new_pc cyc %0d got %h exp %h", c, new_pc, m_pc); end
      checks++; if (mc_busy !== (m_rem > 0)) begin errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", c, mc_busy, (m_rem > 0)); end
      checks++; if (mc_done !== (m_rem == 1)) begin errors++; $display("FAIL rnd_done cyc %0d got %b exp %b", c, mc_done, (m_rem == 1)); end
      tick();
    end
    clear_inputs(); #1;
`ifdef PIPE_CTRL_PERF_EN
    checks++; if (perf_stall_cyc !== 32'(m_perf_stall)) begin errors++; $display("FAIL rnd_perf_stall got %0d exp %0d", perf_stall_cyc, m_perf_stall); end
    checks++; if (perf_flush_cnt !== 32'(m_perf_flush)) begin errors++; $display("FAIL rnd_perf_flush got %0d exp %0d", perf_flush_cnt, m_perf_flush); end
`endif
    tick();
  endtask

  initial begin
    rst = 1'b1;
    m_rem = 0; m_fl = 1'b0; m_pc = 32'h0;
    m_perf_stall = 0; m_perf_flush = 0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_stall_priority();
    test_mc_op();
    test_mc_edge();
    test_exception_abort();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
